// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU arbiter: opcodes, flag positions, enable positions and FSM states.
package fpu_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_MUL  = 3'd1;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_SQRT = 3'd3;
    localparam logic [2:0] OP_CMP  = 3'd4;

    localparam int F_GREAT   = 0;
    localparam int F_EQ      = 1;
    localparam int F_LESS    = 2;
    localparam int F_OV      = 3;
    localparam int F_UN      = 4;
    localparam int F_INV     = 5;
    localparam int F_INEXACT = 6;
    localparam int F_DIVZ    = 7;
    localparam int F_TOUT    = 8;

    localparam int EN_ADD = 0;
    localparam int EN_MUL = 1;
    localparam int EN_SQR = 2;
    localparam int EN_DIV = 3;
    localparam int EN_CMP = 4;

    localparam logic [8:0] FLAG_INV  = 9'(1) << F_INV;
    localparam logic [8:0] FLAG_TOUT = 9'(1) << F_TOUT;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_CMP;
    endfunction

    // The enable vector is ordered differently from the opcode numbering (div/sqrt swap).
    function automatic logic [4:0] op_enable(input logic [2:0] op);
        logic [4:0] en;
        en = '0;
        case (op)
            OP_ADD:  en[EN_ADD] = 1'b1;
            OP_MUL:  en[EN_MUL] = 1'b1;
            OP_DIV:  en[EN_DIV] = 1'b1;
            OP_SQRT: en[EN_SQR] = 1'b1;
            OP_CMP:  en[EN_CMP] = 1'b1;
            default: en = '0;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/fpu_arb_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap-around.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    logic [2*NREQ-1:0] doubled;
    logic [NREQ-1:0]   rotated;
    logic [IDW:0]      sum;

    // Rotate so that ptr lands on bit 0, then take the lowest set bit and map it back.
    always_comb begin
        doubled = {req, req} >> ptr;
        rotated = doubled[NREQ-1:0];
        any     = 1'b0;
        idx     = '0;
        sum     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any && rotated[i]) begin
                any = 1'b1;
                sum = {1'b0, ptr} + (IDW+1)'(i);
                if (sum >= (IDW+1)'(NREQ)) begin
                    sum = sum - (IDW+1)'(NREQ);
                end
                idx = sum[IDW-1:0];
            end
        end
        grant = any ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/fpu_arb.sv
// Shares one FPU between NREQ requesters: round-robin grant, load/run sequencing, timeout,
// and a single registered response channel tagged with the owner's ID.
module fpu_arb
    import fpu_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int IDW     = 3,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [3*NREQ-1:0] req_opcode,
    input  logic [32*NREQ-1:0] req_a,
    input  logic [32*NREQ-1:0] req_b,
    input  logic [3*NREQ-1:0] req_rm,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [31:0]       rsp_data,
    output logic [8:0]        rsp_flags,
    output logic [31:0]       fpu_in1,
    output logic [31:0]       fpu_in2,
    output logic [2:0]        fpu_opcode,
    output logic [2:0]        fpu_round,
    output logic              fpu_rstp,
    output logic              fpu_act,
    output logic [4:0]        fpu_en,
    input  logic [31:0]       fpu_out,
    input  logic [8:0]        fpu_flags,
    input  logic              fpu_done
);

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gnt_id;
    logic [15:0]     cnt;
    logic [NREQ-1:0] pick_grant;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;
    logic [2:0]      sel_op;
    logic [2:0]      sel_rm;
    logic [31:0]     sel_a;
    logic [31:0]     sel_b;
    logic            timeout_hit;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        sel_op = '0;
        sel_rm = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (pick_idx == IDW'(r)) begin
                sel_op = req_opcode[3*r +: 3];
                sel_rm = req_rm[3*r +: 3];
                sel_a  = req_a[32*r +: 32];
                sel_b  = req_b[32*r +: 32];
            end
        end
    end

    // Ready is the only combinational output; it is forced low while reset is held.
    assign req_ready   = (state == IDLE && !rst) ? pick_grant : '0;
    assign timeout_hit = (cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            gnt_id     <= '0;
            cnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            rsp_flags  <= '0;
            fpu_in1    <= '0;
            fpu_in2    <= '0;
            fpu_opcode <= '0;
            fpu_round  <= '0;
            fpu_rstp   <= 1'b0;
            fpu_act    <= 1'b0;
            fpu_en     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt_id <= pick_idx;
                        if (!op_legal(sel_op)) begin
                            rsp_valid <= 1'b1;
                            rsp_id    <= pick_idx;
                            rsp_data  <= '0;
                            rsp_flags <= FLAG_INV;
                            state     <= RESP;
                        end else begin
                            fpu_in1    <= sel_a;
                            fpu_in2    <= sel_b;
                            fpu_opcode <= sel_op;
                            fpu_round  <= sel_rm;
                            fpu_en     <= op_enable(sel_op);
                            fpu_rstp   <= 1'b1;
                            state      <= LOAD;
                        end
                    end
                end

                LOAD: begin
                    fpu_rstp <= 1'b0;
                    fpu_act  <= 1'b1;
                    cnt      <= '0;
                    state    <= RUN;
                end

                RUN: begin
                    cnt <= cnt + 16'd1;
                    // A done arriving in the same cycle as the timeout takes priority.
                    if (fpu_done || timeout_hit) begin
                        if (fpu_done) begin
                            rsp_data  <= (fpu_opcode == OP_CMP) ? 32'd0 : fpu_out;
                            rsp_flags <= fpu_flags & ~FLAG_TOUT;
                        end else begin
                            rsp_data  <= '0;
                            rsp_flags <= FLAG_TOUT;
                        end
                        rsp_valid  <= 1'b1;
                        rsp_id     <= gnt_id;
                        cnt        <= '0;
                        fpu_in1    <= '0;
                        fpu_in2    <= '0;
                        fpu_opcode <= '0;
                        fpu_round  <= '0;
                        fpu_act    <= 1'b0;
                        fpu_en     <= '0;
                        state      <= RESP;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr       <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fpu_arb.md
# fpu_arb

Round-robin arbiter and sequencer that shares one `fpu` instance between `NREQ` independent requesters. Each requester issues an operation with a valid/ready handshake. The block grants one request at a time, drives the FPU operands, opcode, rounding mode and enables, and pulses the FPU reset. It waits for `done`, or for a timeout, and returns the registered result with the requester ID on a single response channel. It sits between the core-side issue logic and the `fpu` top level.

## Interface
- `NREQ`, 2: number of requesters, 2..8.
- `IDW`, 3: width of the requester ID; must satisfy 2**IDW ≥ NREQ.
- `TIMEOUT`, 255: maximum number of RUN cycles to wait for `fpu_done`, 1..65535.

Ports. The clock is `clk`. The reset `rst` is asynchronous and active-high.
- `clk` in 1: clock.
- `rst` in 1: asynchronous active-high reset.
- `req_valid` in NREQ: request present, one bit per requester.
- `req_ready` out NREQ: request accepted this cycle, one-hot or zero.
- `req_opcode` in 3*NREQ: per-requester opcode; 0 add, 1 mul, 2 div, 3 sqrt, 4 compare.
- `req_a`, `req_b` in 32*NREQ: per-requester operands.
- `req_rm` in 3*NREQ: per-requester rounding mode.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_id` out IDW: index of the requester that owns the result.
- `rsp_data` out 32: FPU result; 0 for compare, timeout and illegal opcode.
- `rsp_flags` out 9: {tout, div_zero, inexact, inv, un, ov, less, eq, great}.
- `fpu_in1`, `fpu_in2` out 32: operands driven to the FPU.
- `fpu_opcode` out 3: opcode driven to the FPU.
- `fpu_round` out 3: rounding mode driven to the FPU.
- `fpu_rstp` out 1: FPU reset pulse.
- `fpu_act` out 1: FPU activate.
- `fpu_en` out 5: {comp, div, sqr, mul, add} enables.
- `fpu_out` in 32: FPU result.
- `fpu_flags` in 9: FPU status flags; bit 8 is tied 0 at the FPU side.
- `fpu_done` in 1: FPU completion.

## Operation
- State machine states: IDLE, LOAD, RUN, RESP.
- IDLE:
  - If any `req_valid` is set, grant the first set bit at or after `ptr` (round-robin, with wrap-around).
  - Assert `req_ready[g]` combinationally in the same cycle.
  - Capture opcode, operands, rounding mode and `g` into registers.
  - If opcode is 5..7, go to RESP with `rsp_data`=0 and only `inv` set in `rsp_flags`; the FPU is not touched.
  - Otherwise go to LOAD.
- LOAD, one cycle:
  - `fpu_rstp`=1; operands, opcode and round are driven from the registers.
  - The enable bit matching the opcode is set, all other enable bits are 0; `fpu_act`=0.
- RUN:
  - `fpu_rstp`=0, `fpu_act`=1, operands, opcode and enables held.
  - A 16-bit cycle counter increments every RUN cycle.
  - When `fpu_done`=1, register `fpu_out` and `fpu_flags`, then go to RESP.
  - When the counter reaches `TIMEOUT` without `fpu_done`, register `rsp_data`=0 and `rsp_flags`={tout=1, rest 0}, then go to RESP.
  - If `fpu_done` and the timeout fall in the same cycle, `fpu_done` wins.
- RESP:
  - `rsp_valid`=1 and all `rsp_*` outputs are held stable until `rsp_ready`.
  - On the handshake, `ptr` becomes (g+1) mod NREQ and the state returns to IDLE.
- FPU operand and control outputs are 0 in IDLE and RESP.
- `req_valid` bits of requesters that are not granted are ignored.
- Requests are not buffered; a requester holds its request until `req_ready`.

## Timing
- Reset values:
  - state IDLE, `ptr`=0, counter 0.
  - `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_flags`=0.
  - All `fpu_*` outputs 0.
- Reset may arrive mid-operation: the state machine aborts to IDLE immediately and no response is produced.
- Accept in cycle 0, LOAD in cycle 1, RUN from cycle 2.
- If `fpu_done` is seen in cycle 2+k, `rsp_valid` rises in cycle 3+k.
- Illegal opcode: `rsp_valid` rises in cycle 1.
- Timeout: `rsp_valid` rises TIMEOUT+2 cycles after accept.
- Throughput: at most one operation in flight.
- The minimum issue-to-issue spacing is 4 cycles when `rsp_ready` is held at 1.
- In RESP, a new grant is not evaluated until the cycle after the handshake.

## Structure
- Shared package `fpu_pkg` holds:
  - opcode constants OP_ADD..OP_CMP;
  - flag bit indices F_GREAT..F_TOUT;
  - the state enum {IDLE, LOAD, RUN, RESP}.
- Sub-module `rr_arbiter`: combinational round-robin pick of a one-hot grant and binary index from `req` and `ptr`, parameterised by NREQ.
- The top level contains the state machine, operand and result registers, and the timeout counter.

## Test plan
- **Single add:** requester 0 issues opcode 0, a=0x3F800000, b=0x40000000; the FPU model asserts done 3 cycles into RUN -> `rsp_valid` in cycle 6, `rsp_id`=0, `rsp_data`=0x40400000, `fpu_rstp` high only in cycle 1.
- **Round-robin fairness:** both requesters hold valid for 4 operations -> grants go 0,1,0,1 and each `req_ready` pulse is one-hot.
- **Illegal opcode:** requester 1 issues opcode 6 -> `rsp_valid` in cycle 1 with `rsp_flags`=0x020 (inv only), `fpu_rstp` never set, `fpu_en`=0 throughout.
- **Timeout:** TIMEOUT=8 and the FPU model never asserts done -> `rsp_valid` 10 cycles after accept, `rsp_flags`=0x100, `rsp_data`=0.
- **Back-pressure:** `rsp_ready`=0 for 5 cycles while requester 1 is valid -> `rsp_*` outputs stable, `req_ready` stays 0, requester 1 is granted the cycle after the handshake.
- **Reset mid-RUN:** assert `rst` in the second RUN cycle -> all outputs 0 asynchronously, the next request after release is granted starting from `ptr`=0.
